// File: rtl/rv_hazard_ctrl.sv
// rtl/rv_hazard_ctrl.sv - uRV stall/kill controller: stall merge, load-use interlock, branch kill window
// Optional statistics counters are built when URV_HAZARD_STATS_EN is defined.
module rv_hazard_ctrl #(
  parameter int         g_NUM_STALL_REQ    = 2,
  parameter logic [7:0] g_W_STALL_MASK     = 8'h00,
  parameter int         g_LOAD_USE_PENALTY = 1,
  parameter int         g_KILL_DEPTH       = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [g_NUM_STALL_REQ-1:0] stall_req_i,
  input  logic                       f_load_hazard_i,
  input  logic                       x_load_i,
  input  logic                       x_bra_i,
  output logic                       f_stall_o,
  output logic                       x_stall_o,
  output logic                       w_stall_o,
  output logic                       f_kill_o,
  output logic                       x_kill_o,
  output logic                       interlock_o,
  input  logic                       stats_clr_i,
  output logic [31:0]                cnt_interlock_o,
  output logic [31:0]                cnt_stall_o,
  output logic [31:0]                cnt_kill_o
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RELEASE} state_t;

  localparam logic [1:0] HOLD_INIT =
    (g_LOAD_USE_PENALTY >= 2) ? 2'(g_LOAD_USE_PENALTY - 2) : 2'd0;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       any_req, w_req, detect, ilk_raw, stall_raw, kill_win;

  assign any_req = |stall_req_i;
  assign w_req   = |(stall_req_i & g_W_STALL_MASK[g_NUM_STALL_REQ-1:0]);
  assign detect  = f_load_hazard_i & x_load_i & ~x_bra_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A taken branch kills the younger dependent instruction, so a pending interlock is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (detect) begin
          if (g_LOAD_USE_PENALTY == 1) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_INIT;
          end
        end
      end
      S_HOLD: begin
        if (x_bra_i) begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
        end else if (!any_req) begin
          if (cnt_q == 2'd0) state_d = S_RELEASE;
          else               cnt_d   = cnt_q - 2'd1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    ilk_raw = 1'b0;
    case (state_q)
      S_IDLE:  ilk_raw = detect;
      S_HOLD:  ilk_raw = 1'b1;
      default: ilk_raw = 1'b0;
    endcase
  end

  assign stall_raw   = any_req | ilk_raw;
  assign interlock_o = ilk_raw & ~rst_i;
  assign f_stall_o   = stall_raw & ~rst_i;
  assign x_stall_o   = stall_raw & ~rst_i;
  assign w_stall_o   = w_req & ~rst_i;

  generate
    if (g_KILL_DEPTH > 1) begin : g_ksr
      logic [g_KILL_DEPTH-2:0] ksr_q;
      // The window only advances on un-stalled cycles so each killed slot really drains.
      always_ff @(posedge clk_i) begin
        if (rst_i)           ksr_q <= '0;
        else if (x_bra_i)    ksr_q <= '1;
        else if (!stall_raw) ksr_q <= ksr_q >> 1;
      end
      assign kill_win = |ksr_q;
    end else begin : g_no_ksr
      assign kill_win = 1'b0;
    end
  endgenerate

  assign f_kill_o = x_bra_i & ~rst_i;
  assign x_kill_o = (x_bra_i | kill_win) & ~rst_i;

`ifdef URV_HAZARD_STATS_EN
  logic [31:0] cnt_ilk_q, cnt_stall_q, cnt_kill_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || stats_clr_i) begin
      cnt_ilk_q   <= 32'd0;
      cnt_stall_q <= 32'd0;
      cnt_kill_q  <= 32'd0;
    end else begin
      cnt_ilk_q   <= cnt_ilk_q   + {31'd0, interlock_o};
      cnt_stall_q <= cnt_stall_q + {31'd0, x_stall_o};
      cnt_kill_q  <= cnt_kill_q  + {31'd0, x_kill_o};
    end
  end

  assign cnt_interlock_o = cnt_ilk_q;
  assign cnt_stall_o     = cnt_stall_q;
  assign cnt_kill_o      = cnt_kill_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign cnt_interlock_o  = 32'd0;
  assign cnt_stall_o      = 32'd0;
  assign cnt_kill_o       = 32'd0;
`endif

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// tb/tb_rv_hazard_ctrl.sv - scoreboard bench for rv_hazard_ctrl against a cycle-count reference model
module tb_rv_hazard_ctrl;

  localparam int         NREQ = 2;
  localparam logic [7:0] WMSK = 8'h02;
  localparam int         PEN  = 3;
  localparam int         KD   = 3;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [NREQ-1:0] stall_req_i = '0;
  logic            f_load_hazard_i = 1'b0, x_load_i = 1'b0, x_bra_i = 1'b0, stats_clr_i = 1'b0;
  logic            f_stall_o, x_stall_o, w_stall_o, f_kill_o, x_kill_o, interlock_o;
  logic [31:0]     cnt_interlock_o, cnt_stall_o, cnt_kill_o;

  rv_hazard_ctrl #(
    .g_NUM_STALL_REQ(NREQ), .g_W_STALL_MASK(WMSK),
    .g_LOAD_USE_PENALTY(PEN), .g_KILL_DEPTH(KD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_req_i(stall_req_i),
    .f_load_hazard_i(f_load_hazard_i), .x_load_i(x_load_i), .x_bra_i(x_bra_i),
    .f_stall_o(f_stall_o), .x_stall_o(x_stall_o), .w_stall_o(w_stall_o),
    .f_kill_o(f_kill_o), .x_kill_o(x_kill_o), .interlock_o(interlock_o),
    .stats_clr_i(stats_clr_i), .cnt_interlock_o(cnt_interlock_o),
    .cnt_stall_o(cnt_stall_o), .cnt_kill_o(cnt_kill_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        fst, xst, wst, fk, xk, ilk;
    logic [31:0] ci, cs, ck;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: remaining hold cycles, pending release slot, remaining kill slots.
  int          m_rem = 0;
  bit          m_rel = 0;
  int          m_kwin = 0;
  logic [31:0] m_ci = 0, m_cs = 0, m_ck = 0;

`ifdef URV_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [NREQ-1:0] req, input logic haz,
                      input logic ld, input logic bra, input logic clr);
    exp_t e;
    logic any, det;
    @(posedge clk_i);
    #1;
    rst_i = rst; stall_req_i = req; f_load_hazard_i = haz;
    x_load_i = ld; x_bra_i = bra; stats_clr_i = clr;
    any = |req;
    det = haz & ld & ~bra;
    if (rst) begin
      e.ilk = 0; e.xst = 0; e.wst = 0; e.fk = 0; e.xk = 0;
    end else begin
      e.ilk = (m_rem > 0) ? 1'b1 : (m_rel ? 1'b0 : det);
      e.xst = any | e.ilk;
      e.wst = |(req & WMSK[NREQ-1:0]);
      e.fk  = bra;
      e.xk  = bra | (m_kwin > 0);
    end
    e.fst = e.xst;
    e.ci = STATS ? m_ci : 32'd0;
    e.cs = STATS ? m_cs : 32'd0;
    e.ck = STATS ? m_ck : 32'd0;
    exp_q.push_back(e);

    if (rst) begin
      m_rem = 0; m_rel = 0; m_kwin = 0;
    end else begin
      if (m_rem > 0) begin
        if (bra) m_rem = 0;
        else if (!any) begin
          m_rem--;
          if (m_rem == 0) m_rel = 1;
        end
      end else if (m_rel) begin
        m_rel = 0;
      end else if (det) begin
        m_rem = PEN - 1;
        m_rel = (PEN == 1);
      end
      if (bra) m_kwin = KD - 1;
      else if (!e.xst && m_kwin > 0) m_kwin--;
    end
    if (rst || clr) begin
      m_ci = 0; m_cs = 0; m_ck = 0;
    end else begin
      m_ci += {31'd0, e.ilk};
      m_cs += {31'd0, e.xst};
      m_ck += {31'd0, e.xk};
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("f_stall", {31'd0, f_stall_o}, {31'd0, e.fst});
        chk("x_stall", {31'd0, x_stall_o}, {31'd0, e.xst});
        chk("w_stall", {31'd0, w_stall_o}, {31'd0, e.wst});
        chk("f_kill", {31'd0, f_kill_o}, {31'd0, e.fk});
        chk("x_kill", {31'd0, x_kill_o}, {31'd0, e.xk});
        chk("interlock", {31'd0, interlock_o}, {31'd0, e.ilk});
        chk("cnt_interlock", cnt_interlock_o, e.ci);
        chk("cnt_stall", cnt_stall_o, e.cs);
        chk("cnt_kill", cnt_kill_o, e.ck);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int budget;
    repeat (3) step(1, 2'b00, 0, 0, 0, 0);
    // load-use detect pulse, then held detect
    step(0, 2'b00, 1, 1, 0, 0);
    repeat (6) step(0, 2'b00, 0, 0, 0, 0);
    repeat (8) step(0, 2'b00, 1, 1, 0, 0);
    // detect with two stalled cycles inside HOLD
    step(0, 2'b00, 1, 1, 0, 0);
    repeat (2) step(0, 2'b01, 0, 0, 0, 0);
    repeat (5) step(0, 2'b00, 0, 0, 0, 0);
    // branch pulse, then branch with a stall in the second cycle
    step(0, 2'b00, 0, 0, 1, 0);
    repeat (4) step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    step(0, 2'b01, 0, 0, 0, 0);
    repeat (4) step(0, 2'b00, 0, 0, 0, 0);
    // branch re-opens an active window
    step(0, 2'b00, 0, 0, 1, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    repeat (4) step(0, 2'b00, 0, 0, 0, 0);
    // detect together with branch; branch during HOLD
    step(0, 2'b00, 1, 1, 1, 0);
    repeat (3) step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 1, 1, 0, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    repeat (4) step(0, 2'b00, 0, 0, 0, 0);
    // writeback mask and reset mid-HOLD with inputs high
    step(0, 2'b01, 0, 0, 0, 0);
    step(0, 2'b10, 0, 0, 0, 0);
    step(0, 2'b11, 0, 0, 0, 0);
    step(0, 2'b00, 1, 1, 0, 0);
    step(1, 2'b11, 1, 1, 1, 0);
    step(1, 2'b11, 1, 1, 1, 0);
    repeat (3) step(0, 2'b00, 0, 0, 0, 0);
    // ten stall cycles, then clear during a stall
    repeat (10) step(0, 2'b01, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    repeat (3) step(0, 2'b01, 0, 0, 0, 0);
    step(0, 2'b01, 0, 0, 0, 1);
    repeat (3) step(0, 2'b00, 0, 0, 0, 0);
    // randomized traffic with sparse branches, clears and resets
    for (int i = 0; i < 3000; i++) begin
      logic [NREQ-1:0] r;
      logic            h, l, b, c, rs;
      r  = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      h  = $urandom_range(0, 2) != 0;
      l  = $urandom_range(0, 1) != 0;
      b  = $urandom_range(0, 7) == 0;
      c  = $urandom_range(0, 63) == 0;
      rs = $urandom_range(0, 199) == 0;
      step(rs, r, h, l, b, c);
    end
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk_i);
      budget--;
    end
    @(posedge clk_i);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_hazard_ctrl.md
# rv_hazard_ctrl

Parametrised pipeline hazard and flush controller for the uRV core, replacing the hard-wired stall/kill glue in the CPU top level. Combines N stall-request sources, runs a load-use interlock FSM with configurable penalty, and generates branch kill windows of configurable depth. Sits beside fetch/exec/writeback and drives their stall and kill inputs.

## Interface

Parameters:
- g_NUM_STALL_REQ, 2: number of stall-request sources (1..8).
- g_W_STALL_MASK, 0: bit i set means source i also stalls writeback.
- g_LOAD_USE_PENALTY, 1: interlock stall cycles per load-use hazard (1..4).
- g_KILL_DEPTH, 2: X-stage kill window length in un-stalled cycles, counted from the branch (1..4).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous active-high reset.
- stall_req_i  in  g_NUM_STALL_REQ  stall requests (exec, writeback, ...).
- f_load_hazard_i  in  1  fetch rs1/rs2 matches rd of instruction in X.
- x_load_i  in  1  instruction in X is a load (combinational).
- x_bra_i  in  1  branch taken in X this cycle.
- f_stall_o  out  1  stall fetch.
- x_stall_o  out  1  stall execute.
- w_stall_o  out  1  stall writeback.
- f_kill_o  out  1  kill fetch output.
- x_kill_o  out  1  kill execute input.
- interlock_o  out  1  load-use interlock active this cycle.
- stats_clr_i  in  1  clear statistics counters.
- cnt_interlock_o, cnt_stall_o, cnt_kill_o  out  32 each  statistics (see Configuration).

## Operation

- any_req = OR of stall_req_i. f_stall_o = x_stall_o = any_req | interlock_o. w_stall_o = OR of (stall_req_i & g_W_STALL_MASK).
- detect = f_load_hazard_i & x_load_i & !x_bra_i.
- Interlock FSM, 2-bit counter cnt:
  - IDLE: interlock_o = detect. On detect: if g_LOAD_USE_PENALTY = 1 go RELEASE, else go HOLD with cnt = g_LOAD_USE_PENALTY-2.
  - HOLD: interlock_o = 1. If !any_req: cnt = 0 -> RELEASE, else cnt decrements. If any_req: state and cnt frozen.
  - RELEASE: interlock_o = 0, detect masked for one cycle; -> IDLE.
  - x_bra_i in HOLD or IDLE-with-detect: interlock cancelled, next state IDLE (younger instruction killed).
- Branch kill: f_kill_o = x_bra_i. x_kill_o = x_bra_i | (ksr != 0). ksr is a (g_KILL_DEPTH-1)-bit shift register loaded all-ones on x_bra_i; otherwise shifts right by one only when !x_stall_o. g_KILL_DEPTH = 1: ksr absent, x_kill_o = x_bra_i.
- Branch during an open kill window reloads ksr (window restarts).
- While rst_i is high: every stall/kill/interlock output is 0, FSM IDLE, cnt 0, ksr 0.

## Timing

- Combinational paths: stall_req_i, f_load_hazard_i, x_load_i, x_bra_i to all stall/kill outputs within the same cycle.
- Interlock with no other stalls: exactly g_LOAD_USE_PENALTY cycles of interlock_o starting on the detect cycle, then one RELEASE cycle.
- Kill window: x_kill_o high on branch cycle plus g_KILL_DEPTH-1 further un-stalled cycles; stalled cycles extend it.
- State updates on rising clk_i; first active cycle after reset is IDLE.

## Configuration

- URV_HAZARD_STATS_EN defined: three 32-bit counters, cleared by rst_i or stats_clr_i (clear wins over increment), wrapping modulo 2^32. cnt_interlock_o increments each cycle interlock_o = 1; cnt_stall_o each cycle x_stall_o = 1; cnt_kill_o each cycle x_kill_o = 1. Values visible one cycle after the counted cycle.
- Not defined: counters not built; cnt_* tied to 0; stats_clr_i ignored.

## Test plan

- Defaults, pulse detect (f_load_hazard_i=1, x_load_i=1) one cycle -> interlock_o/x_stall_o high 1 cycle, RELEASE next cycle masks detect even if held high, re-triggers on cycle 3.
- g_LOAD_USE_PENALTY=3, detect with stall_req_i=01 asserted 2 cycles during HOLD -> interlock_o high 5 cycles total, x_stall_o high throughout.
- g_KILL_DEPTH=3, x_bra_i pulse, no stalls -> f_kill_o 1 cycle, x_kill_o 3 cycles; with x_stall_o in cycle 2 -> x_kill_o 4 cycles.
- Detect and x_bra_i in same cycle, and x_bra_i during HOLD -> interlock_o 0 / FSM IDLE next cycle, x_kill_o asserted.
- g_W_STALL_MASK=10, stall_req_i=01 -> w_stall_o=0, x_stall_o=1; stall_req_i=10 -> both 1; rst_i mid-HOLD with inputs high -> all outputs 0.
- URV_HAZARD_STATS_EN: 10 stall cycles -> cnt_stall_o=10; stats_clr_i during stall -> 0 next cycle; preload near 0xFFFFFFFF via long run or force -> wraps to 0.
